pci_ddr_req: RTL and testbench

// - PCI-target-to-DDR request sequencer. Sits between the PCI core's target

---
 rtl/pci_ddr_req_if.sv | 41 ++++
 rtl/pci_ddr_req.sv | 210 +++++++++++++++++++++
 tb/tb_pci_ddr_req.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pci_ddr_req_if.sv
// Target-side and DDR-side signal bundle for the PCI-to-DDR request sequencer.
// slave: the sequencer's view; master: the PCI core / ddr_top environment view.
interface pci_ddr_req_if #(
    parameter int ADDR_W = 27
) ();
    // PCI target side
    logic [31:0]       addr;
    logic              base_hit;
    logic              s_wrdn;
    logic              s_data;
    logic              s_data_vld;
    logic [31:0]       adio_out;
    logic [3:0]        s_cbe;
    logic              s_ready;
    logic              s_term;
    logic [31:0]       adio_in;
    // DDR controller side
    logic              ddr_req;
    logic              ddr_wr;
    logic [ADDR_W-1:0] ddr_addr;
    logic [31:0]       ddr_wdata;
    logic [3:0]        ddr_be;
    logic              ddr_ack;
    logic              ddr_not_ready;
    logic              ddr_rvalid;
    logic [31:0]       ddr_rdata;

    modport slave (
        input  addr, base_hit, s_wrdn, s_data, s_data_vld, adio_out, s_cbe,
        output s_ready, s_term, adio_in,
        output ddr_req, ddr_wr, ddr_addr, ddr_wdata, ddr_be,
        input  ddr_ack, ddr_not_ready, ddr_rvalid, ddr_rdata
    );

    modport master (
        output addr, base_hit, s_wrdn, s_data, s_data_vld, adio_out, s_cbe,
        input  s_ready, s_term, adio_in,
        input  ddr_req, ddr_wr, ddr_addr, ddr_wdata, ddr_be,
        output ddr_ack, ddr_not_ready, ddr_rvalid, ddr_rdata
    );
endinterface

// File: rtl/pci_ddr_req.sv
// PCI-target-to-DDR request sequencer: posts target writes into a FIFO that
// drains to DDR, and services single-word reads after flushing posted writes.
// Ports: clk, rst (sync, active-low), bus (pci_ddr_req_if.slave) carrying the
// PCI target handshake/data and the ddr_top request/response signals.
module pci_ddr_req #(
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 27,
    parameter int RD_TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    pci_ddr_req_if.slave bus
);
    localparam int WW = ADDR_W - 2;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = WW + 36;
    localparam int TW = $clog2(RD_TIMEOUT) + 1;

    localparam logic [CW-1:0] RDY_MAX = CW'(FIFO_DEPTH - 2);
    localparam logic [TW-1:0] TO_LAST = TW'(RD_TIMEOUT - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WRITE     = 3'd1;
    localparam logic [2:0] S_FLUSH     = 3'd2;
    localparam logic [2:0] S_READ_REQ  = 3'd3;
    localparam logic [2:0] S_READ_WAIT = 3'd4;
    localparam logic [2:0] S_READ_DATA = 3'd5;

    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [2:0]    state_q, state_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic [WW-1:0] raddr_q, raddr_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          drop_q, drop_d;
    logic          wr_done_q, wr_done_d;
    logic          s_data_q, s_data_d;
    logic          s_ready_q, s_ready_d;
    logic          s_term_q, s_term_d;
    logic [31:0]   adio_in_q, adio_in_d;

    logic          fifo_ne;
    logic          push;
    logic          pop;
    logic          wr_req;
    logic          rd_req;
    logic          s_data_fall;
    logic [EW-1:0] head;

    // Only the DDR byte-address bits of the PCI address are meaningful.
    logic unused_addr;
    assign unused_addr = ^{bus.addr[31:ADDR_W], bus.addr[1:0]};

    assign fifo_ne     = (count_q != '0);
    assign head        = mem_q[rd_ptr_q];
    assign s_data_d    = bus.s_data;
    assign s_data_fall = s_data_q & ~bus.s_data;
    assign push        = (state_q == S_WRITE) & bus.s_data_vld & s_ready_q;

    // Posted writes always win the request port, so a read can only be
    // presented once the FIFO is empty and no stale read is outstanding.
    assign wr_req = fifo_ne & ~bus.ddr_not_ready;
    assign rd_req = (state_q == S_READ_REQ) & ~fifo_ne & ~drop_q
                  & ~bus.ddr_not_ready;
    assign pop    = wr_req & bus.ddr_ack;

    assign bus.ddr_req   = wr_req | rd_req;
    assign bus.ddr_wr    = wr_req;
    assign bus.ddr_addr  = wr_req ? {head[EW-1 -: WW], 2'b00} :
                           rd_req ? {raddr_q, 2'b00} : '0;
    assign bus.ddr_wdata = wr_req ? head[35:4] : '0;
    assign bus.ddr_be    = wr_req ? head[3:0] : '0;

    assign bus.s_ready = s_ready_q;
    assign bus.s_term  = s_term_q;
    assign bus.adio_in = adio_in_q;

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        raddr_d   = raddr_q;
        tcnt_d    = tcnt_q;
        drop_d    = drop_q;
        wr_done_d = wr_done_q;
        adio_in_d = adio_in_q;
        s_ready_d = 1'b0;
        s_term_d  = 1'b0;

        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // The first response after a timed-out read belongs to that read.
        if (drop_q && bus.ddr_rvalid) begin
            drop_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                wr_done_d = 1'b0;
                tcnt_d    = '0;
                if (bus.base_hit) begin
                    if (bus.s_wrdn) begin
                        wcnt_d  = bus.addr[ADDR_W-1:2];
                        state_d = S_WRITE;
                    end else begin
                        raddr_d = bus.addr[ADDR_W-1:2];
                        state_d = fifo_ne ? S_FLUSH : S_READ_REQ;
                    end
                end
            end
            S_WRITE: begin
                if (push) begin
                    wcnt_d = wcnt_q + WW'(1);
                end
                // A push while s_term is up is the last word before the
                // 1 KB boundary; no further phases are accepted.
                wr_done_d = wr_done_q | (push & s_term_q);
                if (s_data_fall) begin
                    state_d = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (!fifo_ne) begin
                    state_d = S_READ_REQ;
                end
            end
            S_READ_REQ: begin
                tcnt_d = '0;
                if (rd_req && bus.ddr_ack) begin
                    state_d = S_READ_WAIT;
                end
            end
            S_READ_WAIT: begin
                if (bus.ddr_rvalid) begin
                    adio_in_d = bus.ddr_rdata;
                    state_d   = S_READ_DATA;
                end else if (tcnt_q == TO_LAST) begin
                    drop_d   = 1'b1;
                    s_term_d = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            S_READ_DATA: begin
                if (bus.s_data_vld || s_data_fall) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Registered handshakes look at the post-cycle FIFO occupancy so
        // the FIFO can never overflow.
        if (state_d == S_WRITE) begin
            s_ready_d = ~wr_done_d & (count_d <= RDY_MAX);
            s_term_d  = ((state_q == S_WRITE) & s_term_q)
                      | (wcnt_d[7:0] == 8'hFF);
        end else if (state_d == S_READ_DATA) begin
            s_ready_d = 1'b1;
            s_term_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {wcnt_q, bus.adio_out, ~bus.s_cbe};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            wcnt_q    <= '0;
            raddr_q   <= '0;
            tcnt_q    <= '0;
            drop_q    <= 1'b0;
            wr_done_q <= 1'b0;
            s_data_q  <= 1'b0;
            s_ready_q <= 1'b0;
            s_term_q  <= 1'b0;
            adio_in_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            wcnt_q    <= wcnt_d;
            raddr_q   <= raddr_d;
            tcnt_q    <= tcnt_d;
            drop_q    <= drop_d;
            wr_done_q <= wr_done_d;
            s_data_q  <= s_data_d;
            s_ready_q <= s_ready_d;
            s_term_q  <= s_term_d;
            adio_in_q <= adio_in_d;
        end
    end
endmodule

// File: tb/tb_pci_ddr_req.sv
// Bench for pci_ddr_req: directed target bursts and reads, with a DDR-request
// scoreboard fed by the stimulus and drained by a monitor thread.
module tb_pci_ddr_req;
    typedef struct packed {
        logic        wr;
        logic [26:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } req_t;

    logic  clk = 1'b0;
    logic  rst = 1'b0;
    int    n_chk = 0;
    int    n_fail = 0;
    req_t  exp_q[$];
    req_t  mon_e;
    logic [63:0] mon_act;
    int    nw;

    pci_ddr_req_if m ();

    pci_ddr_req dut (
        .clk (clk),
        .rst (rst),
        .bus (m)
    );

    initial forever #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    function automatic logic [31:0] wdat(input logic [24:0] w);
        return {16'hC0DE, w[15:0]} ^ 32'h0000_5A00;
    endfunction

    task automatic wait_drain();
        int g = 0;
        while ((exp_q.size() != 0 || m.ddr_req) && g < 500) begin
            tick();
            g++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic burst(input logic [24:0] start, input int n,
                         input logic [3:0] cbe, input bit ack_low,
                         output int k);
        int   guard = 0;
        int   stall = 0;
        bit   pushed;
        bit   last = 1'b0;
        logic [24:0] cw;
        logic [31:0] d;
        k = 0;
        m.addr     = {5'b0, start, 2'b00};
        m.s_wrdn   = 1'b1;
        m.base_hit = 1'b1;
        tick();
        m.base_hit = 1'b0;
        m.s_data   = 1'b1;
        while (k < n && !last && guard < 300) begin
            guard++;
            if (m.s_term && !m.s_ready && k > 0) break;
            pushed = m.s_ready;
            cw = start + 25'(k);
            d  = wdat(cw);
            m.adio_out   = d;
            m.s_cbe      = cbe;
            m.s_data_vld = pushed;
            if (pushed) begin
                exp_q.push_back({1'b1, {cw, 2'b00}, d, ~cbe});
                check("s_term_phase", 64'(m.s_term), 64'(cw[7:0] == 8'hFF));
                last = m.s_term;
                k++;
                stall = 0;
            end else begin
                stall++;
            end
            if (ack_low && stall >= 3 && !m.ddr_ack) m.ddr_ack = 1'b1;
            tick();
            m.s_data_vld = 1'b0;
            if (pushed && !m.ddr_ack) begin
                check("s_ready_level", 64'(m.s_ready), 64'(k < 15));
            end
        end
        check("burst_budget", 64'(guard < 300), 64'd1);
        m.s_data = 1'b0;
        tick();
        tick();
    endtask

    task automatic rd_issue(input logic [24:0] word);
        exp_q.push_back({1'b0, {word, 2'b00}, 32'h0, 4'h0});
        m.addr     = {5'b0, word, 2'b00};
        m.s_wrdn   = 1'b0;
        m.base_hit = 1'b1;
        tick();
        m.base_hit = 1'b0;
        m.s_data   = 1'b1;
    endtask

    task automatic wait_accept();
        int g = 0;
        while (!(m.ddr_req && m.ddr_ack && !m.ddr_wr) && g < 300) begin
            tick();
            g++;
        end
        check("rd_req_issued", 64'(g < 300), 64'd1);
        tick();
    endtask

    task automatic rd_finish(input logic [31:0] data);
        wait_accept();
        tick();
        tick();
        m.ddr_rvalid = 1'b1;
        m.ddr_rdata  = data;
        tick();
        m.ddr_rvalid = 1'b0;
        check("rd_adio_in", 64'(m.adio_in), 64'(data));
        check("rd_ready_term", 64'({m.s_ready, m.s_term}), 64'd3);
        m.s_data_vld = 1'b1;
        tick();
        m.s_data_vld = 1'b0;
        m.s_data     = 1'b0;
        check("rd_one_phase", 64'({m.s_ready, m.s_term}), 64'd0);
        tick();
    endtask

    initial begin
        m.addr = '0;
        m.base_hit = 1'b0;
        m.s_wrdn = 1'b0;
        m.s_data = 1'b0;
        m.s_data_vld = 1'b0;
        m.adio_out = '0;
        m.s_cbe = '0;
        m.ddr_ack = 1'b1;
        m.ddr_not_ready = 1'b0;
        m.ddr_rvalid = 1'b0;
        m.ddr_rdata = '0;

        fork
            forever begin
                @(negedge clk);
                if (m.ddr_req === 1'b1 && m.ddr_ack === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        check("ddr_extra_req", 64'(exp_q.size()), 64'd1);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (mon_e.wr) begin
                            mon_act = {m.ddr_wr, m.ddr_addr, m.ddr_wdata,
                                       m.ddr_be};
                            check("ddr_write", mon_act, mon_e);
                        end else begin
                            mon_act = {m.ddr_wr, m.ddr_addr, 36'h0};
                            check("ddr_read", mon_act, mon_e);
                        end
                    end
                end
            end
        join_none

        repeat (3) tick();
        check("rst_outputs",
              64'({m.s_ready, m.s_term, m.ddr_req, m.ddr_wr}), 64'd0);
        check("rst_adio_in", 64'(m.adio_in), 64'd0);
        rst = 1'b1;
        tick();

        // 4 words at byte 0x100, all byte lanes enabled
        burst(25'h40, 4, 4'h0, 1'b0, nw);
        check("burst4_words", 64'(nw), 64'd4);
        wait_drain();

        // 20 words with the DDR stalled: FIFO fills to 15 then backs off
        m.ddr_ack = 1'b0;
        burst(25'h100, 20, 4'b0101, 1'b1, nw);
        check("burst20_words", 64'(nw), 64'd20);
        m.ddr_ack = 1'b1;
        wait_drain();

        // 1 KB boundary: start at word 0xFC, expect 4 words then disconnect
        burst(25'hFC, 8, 4'h0, 1'b0, nw);
        check("boundary_words", 64'(nw), 64'd4);
        wait_drain();

        // 3 posted writes, then a read that must wait for all of them
        m.ddr_ack = 1'b0;
        burst(25'h200, 3, 4'h0, 1'b0, nw);
        check("posted_words", 64'(nw), 64'd3);
        rd_issue(25'h41);
        repeat (3) tick();
        check("flush_s_ready", 64'(m.s_ready), 64'd0);
        check("flush_head_is_write", 64'({m.ddr_req, m.ddr_wr}), 64'd3);
        m.ddr_ack = 1'b1;
        rd_finish(32'hCAFE_F00D);

        // Read that never gets data: retry after the timeout, drop late data
        rd_issue(25'h80);
        wait_accept();
        begin
            int i = 0;
            while (!m.s_term && i < 100) begin
                tick();
                i++;
            end
            check("timeout_cycles", 64'(i), 64'd64);
            check("timeout_s_ready", 64'(m.s_ready), 64'd0);
        end
        m.s_data = 1'b0;
        repeat (4) tick();
        m.ddr_rvalid = 1'b1;
        m.ddr_rdata  = 32'hDEAD_BEEF;
        tick();
        m.ddr_rvalid = 1'b0;
        tick();
        check("drop_adio_in", 64'(m.adio_in), 64'h0000_0000_CAFE_F00D);
        check("drop_s_ready", 64'(m.s_ready), 64'd0);

        // Next read proceeds once the stale response is gone
        rd_issue(25'hC0);
        rd_finish(32'h1234_5678);
        wait_drain();

        // Reset mid-burst with 5 words posted
        m.ddr_ack = 1'b0;
        m.addr = {5'b0, 25'h180, 2'b00};
        m.s_wrdn = 1'b1;
        m.base_hit = 1'b1;
        tick();
        m.base_hit = 1'b0;
        m.s_data = 1'b1;
        begin
            int k = 0;
            int g = 0;
            bit p;
            while (k < 5 && g < 50) begin
                p = m.s_ready;
                m.s_data_vld = p;
                m.adio_out = 32'h1111_0000 + 32'(k);
                tick();
                m.s_data_vld = 1'b0;
                if (p) k++;
                g++;
            end
            check("prereset_words", 64'(k), 64'd5);
        end
        check("prereset_req", 64'({m.ddr_req, m.ddr_wr}), 64'd3);
        rst = 1'b0;
        tick();
        check("midrst_outputs",
              64'({m.s_ready, m.s_term, m.ddr_req, m.ddr_wr}), 64'd0);
        check("midrst_adio_in", 64'(m.adio_in), 64'd0);
        rst = 1'b1;
        m.s_data = 1'b0;
        m.ddr_ack = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            check("postrst_fifo_empty", 64'(m.ddr_req), 64'd0);
        end

        // Writes held back while DDR initialises, then drained
        m.ddr_not_ready = 1'b1;
        burst(25'h10, 2, 4'b1100, 1'b0, nw);
        check("notready_words", 64'(nw), 64'd2);
        check("notready_hold", 64'(m.ddr_req), 64'd0);
        m.ddr_not_ready = 1'b0;
        wait_drain();

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
